biquad_sequencer: RTL
=====================

BIQUAD_SEQUENCER -- requirements
Module: biquad_sequencer

Interface
REQ-001 Parameter COEF_FRAC, default 30: fractional bits of coefficients (Q2.30).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; the same net resets the attached filter memory block.
REQ-004 in_valid  input  1  new sample x_in offered.
REQ-005 in_ready  output  1  high only in IDLE; a sample is accepted on in_valid & in_ready.
REQ-006 x_in  input  32  signed input sample.
REQ-007 b0, b1, b2, a1, a2  input  32 each  signed Q2.30 coefficients, captured at sample accept.
REQ-008 dir  output  3  tap select to the memory block.
REQ-009 x_enable, y_enable  output  1 each  shift strobes to the memory block.
REQ-010 x  output  32  captured x[n] to the memory block.
REQ-011 y  output  32  last computed output y to the memory block; also the filter result.
REQ-012 out_mem  input  32  tap data from the memory block: combinational for dir 0 and 3, one-cycle registered for dir 1, 2 and 4.
REQ-013 out_valid  output  1  one-cycle pulse marking a new y.

Function
REQ-014 The block SHALL compute y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2] using one shared multiplier.
REQ-015 The FSM SHALL have states IDLE, T1, T2, T3, T4, T5, T6, ROUND and UPD, each lasting exactly one cycle except IDLE.
REQ-016 IDLE: dir=0; on accept, latch x_in into x and all five coefficients, clear the accumulator, and go to T1.
REQ-017 T1: dir=1, no accumulate.
REQ-018 T2: dir=2, acc += b1*out_mem.
REQ-019 T3: dir=4, acc += b2*out_mem.
REQ-020 T4: dir=4 (held, so out_mem stays registered), acc -= a2*out_mem.
REQ-021 T5: dir=0, acc += b0*out_mem.
REQ-022 T6: dir=3, acc -= a1*out_mem.
REQ-023 Transition order SHALL be T1 -> T2 -> T3 -> T4 -> T5 -> T6 -> ROUND.
REQ-024 Products SHALL be full 64-bit signed; the accumulator SHALL be 68-bit signed and never wrap.
REQ-025 ROUND SHALL compute r = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC (arithmetic shift).
REQ-026 ROUND SHALL saturate r to [-2^31, 2^31-1] and register it as y_new.
REQ-027 UPD: y <= y_new, x_enable=1, y_enable=1 and out_valid=1 for this cycle only, dir=0, then go to IDLE.
REQ-028 In UPD, y SHALL present y_new combinationally so the memory block captures mem[3] = y[n].
REQ-029 y SHALL hold its value between UPD cycles.
REQ-030 Period SHALL be 9 cycles per sample minimum; output y[n] SHALL be valid 8 cycles after the accept edge.
REQ-031 in_valid outside IDLE SHALL be ignored with no sample loss flag; the upstream source holds its data.
REQ-032 x_enable and y_enable SHALL be low in every state except UPD.
REQ-033 Coefficient port changes after accept SHALL NOT affect the sample in flight.

Reset
REQ-034 reset SHALL force IDLE, dir=0, x=0, y=0, accumulator=0, latched coefficients=0, x_enable=y_enable=out_valid=0, and in_ready=1 on the following cycle.
REQ-035 reset mid-sequence SHALL abort the sample with no out_valid and no memory shift; the next accepted sample SHALL be computed against zeroed history.

Structure
REQ-036 Package biquad_pkg SHALL hold COEF_FRAC, ACC_W=68, the dir codes (0,1,2,3,4) and the FSM state encoding.
REQ-037 Sub-module biquad_mac SHALL contain the multiplier, add/subtract select, accumulator, and the round/saturate stage.
REQ-038 The FSM and port registers SHALL reside in biquad_sequencer.

Verification
REQ-039 b0=0x40000000, others 0; x_in=100 -> out_valid 8 cycles after accept with y=100; dir trace across T1..T6 = 1,2,4,4,0,3.
REQ-040 b1=0x40000000, others 0; samples 5 then 7 -> y=0 then y=5.
REQ-041 b0=0x40000000, a1=0xC0000000 (-1.0); samples 1,0,0 -> y=1,1,1.
REQ-042 b0=b1=0x40000000; samples 0x7FFFFFFF twice -> second y=0x7FFFFFFF (saturated); with samples 0x80000000 twice -> second y=0x80000000.
REQ-043 Assert reset during T3 of the second sample -> no out_valid, y=0, in_ready=1 next cycle; next sample 100 with b0=1.0 -> y=100.
REQ-044 in_valid held high continuously -> accepts exactly every 9 cycles, in_ready low in T1..UPD, and x_enable/y_enable pulse once per sample.

Source files
------------

// File: rtl/biquad_pkg.sv
// rtl/biquad_pkg.sv - shared constants, tap codes and state encoding for the biquad sequencer
package biquad_pkg;

  localparam int COEF_FRAC = 30;
  localparam int ACC_W     = 68;

  // Tap select codes understood by the filter memory block
  localparam logic [2:0] DIR_X0 = 3'd0;  // x[n], combinational
  localparam logic [2:0] DIR_X1 = 3'd1;  // x[n-1], registered
  localparam logic [2:0] DIR_X2 = 3'd2;  // x[n-2], registered
  localparam logic [2:0] DIR_Y1 = 3'd3;  // y[n-1], combinational
  localparam logic [2:0] DIR_Y2 = 3'd4;  // y[n-2], registered

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_T1    = 4'd1,
    ST_T2    = 4'd2,
    ST_T3    = 4'd3,
    ST_T4    = 4'd4,
    ST_T5    = 4'd5,
    ST_T6    = 4'd6,
    ST_ROUND = 4'd7,
    ST_UPD   = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    MAC_NONE = 2'd0,
    MAC_CLR  = 2'd1,
    MAC_ADD  = 2'd2,
    MAC_SUB  = 2'd3
  } mac_op_t;

endpackage

// File: rtl/biquad_mac.sv
// rtl/biquad_mac.sv - shared multiplier, 68-bit accumulator and round/saturate stage
module biquad_mac
  import biquad_pkg::*;
#(
  parameter int FRAC = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  mac_op_t     i_op,
  input  logic [31:0] i_coef,
  input  logic [31:0] i_data,
  input  logic        i_round,
  output logic [31:0] o_y_new
);

  localparam logic signed [ACC_W-1:0] SAT_MAX  = (ACC_W'(1) <<< 31) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = -(ACC_W'(1) <<< 31);
  localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(1) <<< (FRAC - 1);

  logic signed [63:0]      w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_rnd;
  logic signed [ACC_W-1:0] w_shift;
  logic [31:0]             w_sat;
  logic signed [ACC_W-1:0] r_acc;
  logic [31:0]             r_y_new;

  // Full-precision product, sign-extended so five terms can never wrap the accumulator
  assign w_prod     = $signed(i_coef) * $signed(i_data);
  assign w_prod_ext = {{(ACC_W - 64){w_prod[63]}}, w_prod};

  // Round half up, then drop the fractional coefficient bits arithmetically
  assign w_rnd   = r_acc + HALF_LSB;
  assign w_shift = w_rnd >>> FRAC;

  // Clamp to the 32-bit signed range
  always_comb begin
    w_sat = w_shift[31:0];
    if (w_shift > SAT_MAX) begin
      w_sat = 32'h7FFF_FFFF;
    end else if (w_shift < SAT_MIN) begin
      w_sat = 32'h8000_0000;
    end
  end

  // Accumulator: cleared at sample accept, add/subtract one product per tap cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else begin
      case (i_op)
        MAC_CLR: r_acc <= '0;
        MAC_ADD: r_acc <= r_acc + w_prod_ext;
        MAC_SUB: r_acc <= r_acc - w_prod_ext;
        default: r_acc <= r_acc;
      endcase
    end
  end

  // Rounded, saturated result captured once per sample
  always_ff @(posedge clk) begin
    if (reset) begin
      r_y_new <= '0;
    end else if (i_round) begin
      r_y_new <= w_sat;
    end
  end

  assign o_y_new = r_y_new;

endmodule

// File: rtl/biquad_sequencer.sv
// rtl/biquad_sequencer.sv - nine-state sequencer driving one shared MAC across the five biquad taps
module biquad_sequencer #(
  parameter int COEF_FRAC = biquad_pkg::COEF_FRAC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_in,
  input  logic [31:0] b0,
  input  logic [31:0] b1,
  input  logic [31:0] b2,
  input  logic [31:0] a1,
  input  logic [31:0] a2,
  output logic [2:0]  dir,
  output logic        x_enable,
  output logic        y_enable,
  output logic [31:0] x,
  output logic [31:0] y,
  input  logic [31:0] out_mem,
  output logic        out_valid
);

  import biquad_pkg::*;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_x;
  logic [31:0] r_y;
  logic [31:0] r_b0;
  logic [31:0] r_b1;
  logic [31:0] r_b2;
  logic [31:0] r_a1;
  logic [31:0] r_a2;

  logic        w_accept;
  logic        w_in_ready;
  logic [2:0]  w_dir;
  mac_op_t     w_op;
  logic [31:0] w_coef;
  logic        w_round;
  logic        w_upd;
  logic [31:0] w_y_new;

  assign w_accept = in_valid & w_in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Sample and coefficient capture at accept; output y updated at the end of UPD
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x  <= '0;
      r_y  <= '0;
      r_b0 <= '0;
      r_b1 <= '0;
      r_b2 <= '0;
      r_a1 <= '0;
      r_a2 <= '0;
    end else begin
      if (w_accept) begin
        r_x  <= x_in;
        r_b0 <= b0;
        r_b1 <= b1;
        r_b2 <= b2;
        r_a1 <= a1;
        r_a2 <= a2;
      end
      if (w_upd) begin
        r_y <= w_y_new;
      end
    end
  end

  // Next state, tap select and MAC control; registered taps are consumed one cycle after selection
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_dir      = DIR_X0;
    w_op       = MAC_NONE;
    w_coef     = '0;
    w_round    = 1'b0;
    w_upd      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_op   = MAC_CLR;
          w_next = ST_T1;
        end
      end
      ST_T1: begin
        w_dir  = DIR_X1;
        w_next = ST_T2;
      end
      ST_T2: begin
        w_dir  = DIR_X2;
        w_op   = MAC_ADD;
        w_coef = r_b1;
        w_next = ST_T3;
      end
      ST_T3: begin
        w_dir  = DIR_Y2;
        w_op   = MAC_ADD;
        w_coef = r_b2;
        w_next = ST_T4;
      end
      ST_T4: begin
        w_dir  = DIR_Y2;
        w_op   = MAC_SUB;
        w_coef = r_a2;
        w_next = ST_T5;
      end
      ST_T5: begin
        w_dir  = DIR_X0;
        w_op   = MAC_ADD;
        w_coef = r_b0;
        w_next = ST_T6;
      end
      ST_T6: begin
        w_dir  = DIR_Y1;
        w_op   = MAC_SUB;
        w_coef = r_a1;
        w_next = ST_ROUND;
      end
      ST_ROUND: begin
        w_round = 1'b1;
        w_next  = ST_UPD;
      end
      ST_UPD: begin
        w_upd  = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  biquad_mac #(
    .FRAC (COEF_FRAC)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .i_op    (w_op),
    .i_coef  (w_coef),
    .i_data  (out_mem),
    .i_round (w_round),
    .o_y_new (w_y_new)
  );

  assign in_ready  = w_in_ready;
  assign dir       = w_dir;
  assign x_enable  = w_upd;
  assign y_enable  = w_upd;
  assign out_valid = w_upd;
  assign x         = r_x;
  // During UPD the memory block must see the fresh result as it shifts
  assign y         = w_upd ? w_y_new : r_y;

endmodule
